// File: rtl/button_conditioner.sv
// Push-button front end: 2-flop sync, debounce, press/release/hold pulses
// and a one-hot-to-index press encoder for the downstream sequence FSM.
module button_conditioner #(
  parameter int unsigned NUM_BTN         = 5,
  parameter int unsigned IDX_W           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] hold_pulse,
  output logic               press_valid,
  output logic [IDX_W-1:0]   press_idx,
  output logic               press_multi
);

  localparam logic [31:0] DLIM = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] HLIM = 32'(HOLD_CYCLES - 1);

  logic [NUM_BTN-1:0] s1_q, s2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] rel_q, rel_d;
  logic [NUM_BTN-1:0] hold_q, hold_d;
  logic [NUM_BTN-1:0] hdone_q, hdone_d;
  logic [31:0]        dcnt_q [NUM_BTN];
  logic [31:0]        dcnt_d [NUM_BTN];
  logic [31:0]        hcnt_q [NUM_BTN];
  logic [31:0]        hcnt_d [NUM_BTN];
  logic               seen;

  always_comb begin
    level_d = level_q;
    hdone_d = hdone_q;
    press_d = '0;
    rel_d   = '0;
    hold_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      dcnt_d[i] = '0;
      hcnt_d[i] = hcnt_q[i];
      if (s2_q[i] != level_q[i]) begin
        if (dcnt_q[i] == DLIM) begin
          level_d[i] = s2_q[i];
          press_d[i] = en & s2_q[i];
          rel_d[i]   = en & ~s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 32'd1;
        end
      end
      // hold timer follows the registered level; hdone blocks repeats
      if (!level_q[i]) begin
        hcnt_d[i]  = '0;
        hdone_d[i] = 1'b0;
      end else if (!hdone_q[i]) begin
        if (hcnt_q[i] == HLIM) begin
          hold_d[i]  = en;
          hdone_d[i] = 1'b1;
        end else begin
          hcnt_d[i] = hcnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
      hdone_q <= '0;
      dcnt_q  <= '{default: '0};
      hcnt_q  <= '{default: '0};
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
      hdone_q <= hdone_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  always_comb begin
    seen        = 1'b0;
    press_idx   = '0;
    press_multi = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (press_q[i]) begin
        if (seen) press_multi = 1'b1;
        else      press_idx   = IDX_W'(i);
        seen = 1'b1;
      end
    end
  end

  assign press_valid   = |press_q;
  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign hold_pulse    = hold_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner against a sample-window
// reference model (last D synchronised samples decide the level).
module tb_button_conditioner;
  localparam int N  = 5;
  localparam int IW = 3;
  localparam int D  = 4;
  localparam int H  = 20;
  localparam logic [31:0] MASK = 32'((1 << D) - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [N-1:0]  btn_raw = '0;
  logic [N-1:0]  btn_level, press_pulse, release_pulse, hold_pulse;
  logic          press_valid, press_multi;
  logic [IW-1:0] press_idx;

  button_conditioner #(
    .NUM_BTN(N), .IDX_W(IW),
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .hold_pulse(hold_pulse),
    .press_valid(press_valid),
    .press_idx(press_idx),
    .press_multi(press_multi)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  logic [N-1:0] m_s1, m_s2, m_lvl, m_pr, m_rl, m_hd;
  logic [31:0]  m_hist [N];
  int           m_high [N];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0;
    m_pr = '0; m_rl = '0; m_hd = '0;
    for (int i = 0; i < N; i++) begin
      m_hist[i] = '0;
      m_high[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic prev;
    for (int i = 0; i < N; i++) begin
      prev = m_lvl[i];
      m_pr[i] = 1'b0; m_rl[i] = 1'b0; m_hd[i] = 1'b0;
      m_hist[i] = {m_hist[i][30:0], m_s2[i]};
      if ((m_hist[i] & MASK) == (prev ? 32'd0 : MASK)) begin
        m_lvl[i] = ~prev;
        m_pr[i]  = en & ~prev;
        m_rl[i]  = en & prev;
      end
      if (prev) begin
        m_high[i]++;
        if (m_high[i] == H) m_hd[i] = en;
      end else begin
        m_high[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw;
  endtask

  task automatic compare();
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (m_pr[i]) idx = IW'(i);
    chk("level",   32'(btn_level),     32'(m_lvl));
    chk("press",   32'(press_pulse),   32'(m_pr));
    chk("release", 32'(release_pulse), 32'(m_rl));
    chk("hold",    32'(hold_pulse),    32'(m_hd));
    chk("valid",   32'(press_valid),   32'(|m_pr));
    chk("idx",     32'(press_idx),     32'(idx));
    chk("multi",   32'(press_multi),   32'($countones(m_pr) > 1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    compare();
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    step();
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    model_reset();
    #1;
    compare();
    steps(2);
    rst_n = 1'b1;
    en = 1'b1;
    steps(3);

    // clean press of L: visible at the sixth edge after the raise
    btn_raw = 5'b00100;
    steps(5);
    chk("s1_early", 32'(press_valid), 32'd0);
    step();
    chk("s1_press", 32'(press_pulse), 32'h04);
    chk("s1_idx", 32'(press_idx), 32'd2);
    steps(30);
    btn_raw = '0;
    steps(10);

    // bounce on D, then stable
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) btn_raw[1] = ~btn_raw[1];
      step();
    end
    btn_raw[1] = 1'b1;
    steps(30);
    btn_raw = '0;
    steps(10);

    // long hold on C
    btn_raw[4] = 1'b1;
    steps(6);
    chk("s3_press", 32'(press_pulse), 32'h10);
    steps(19);
    chk("s3_nohold", 32'(hold_pulse), 32'd0);
    step();
    chk("s3_hold", 32'(hold_pulse), 32'h10);
    steps(25);
    btn_raw[4] = 1'b0;
    steps(5);
    step();
    chk("s3_rel", 32'(release_pulse), 32'h10);
    steps(5);

    // simultaneous D and R
    btn_raw = 5'b01010;
    steps(6);
    chk("s4_press", 32'(press_pulse), 32'h0a);
    chk("s4_multi", 32'(press_multi), 32'd1);
    steps(25);
    btn_raw = '0;
    steps(10);

    // enable gating over a full press/release of U
    en = 1'b0;
    pulses = 0;
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      pulses += $countones({press_pulse, release_pulse, hold_pulse});
    end
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      pulses += $countones({press_pulse, release_pulse, hold_pulse});
    end
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      pulses += $countones({press_pulse, release_pulse, hold_pulse});
    end
    chk("s5_pulses", 32'(pulses), 32'd0);

    // reset while R is held and qualified
    btn_raw[3] = 1'b1;
    steps(12);
    do_reset();
    chk("s6_lvl", 32'(btn_level), 32'd0);
    steps(5);
    step();
    chk("s6_press", 32'(press_pulse), 32'h08);
    steps(19);
    step();
    chk("s6_hold", 32'(hold_pulse), 32'h08);
    btn_raw = '0;
    steps(10);

    // random activity with bursts, enable drops and rare resets
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 29) == 0) btn_raw[i] = ~btn_raw[i];
      if ($urandom_range(0, 59) == 0)
        btn_raw[$urandom_range(0, N - 1)] ^= 1'b1;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 799) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end stage between the raw board push-buttons (btnU/btnD/btnL/btnR/btnC) and the unlock-sequence / display control logic. Per button, it provides:
- synchronisation into clk,
- debouncing,
- single-cycle press, release and long-hold pulses.

It also emits an encoded "one press event" (index + valid + multi-press flag) so the downstream sequence FSM advances exactly once per physical press. That downstream FSM never samples a raw button level.

Parameters:
NUM_BTN, 5, number of buttons; bit order U=0, D=1, L=2, R=3, C=4
IDX_W, 3, width of press_idx; must satisfy 2**IDX_W >= NUM_BTN
DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a synchronised input must differ from the stable level before it is accepted (10 ms at 100 MHz); legal range 1..2**32-1
HOLD_CYCLES, 100_000_000, clk cycles btn_level must stay high before hold_pulse fires (1 s at 100 MHz); legal range 1..2**32-1

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
en  input  1  event enable; when low, all pulse outputs are forced 0, and debouncing and hold counting keep running
btn_raw  input  NUM_BTN  raw asynchronous button levels, active-high
btn_level  output  NUM_BTN  debounced stable level per button
press_pulse  output  NUM_BTN  1-cycle pulse on accepted 0->1 of btn_level
release_pulse  output  NUM_BTN  1-cycle pulse on accepted 1->0 of btn_level
hold_pulse  output  NUM_BTN  1-cycle pulse when held HOLD_CYCLES cycles
press_valid  output  1  OR of press_pulse
press_idx  output  IDX_W  lowest set index of press_pulse; 0 when press_valid=0
press_multi  output  1  more than one press_pulse bit set this cycle

Behaviour:
- Reset (async assert, sync release by board convention): all synchroniser flops, btn_level, debounce counters, hold counters, hold-done flags and all pulse registers go to 0. press_valid, press_idx and press_multi read 0.
- Synchroniser: 2 flops per bit, btn_raw -> s1 -> s2. Only s2 is used downstream.
- Debounce, per bit, 32-bit counter dcnt:
  - If s2 == btn_level: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
- Debounce latency: with btn_raw rising before clock edge E0 and held, btn_level rises at edge E(DEBOUNCE_CYCLES+1).
- Glitch rejection: any excursion of s2 lasting fewer than DEBOUNCE_CYCLES cycles produces no change, and dcnt returns to 0.
- Edge pulses are registered on the same edge as the btn_level update, so each pulse is coincident with the first cycle of the new level:
  - press_pulse[i] <= en & (accepted flip to 1)
  - release_pulse[i] <= en & (accepted flip to 0)
  - Each is high exactly one cycle.
- Hold, per bit, 32-bit counter hcnt and flag hdone:
  - While btn_level=0: hcnt <= 0 and hdone <= 0.
  - While btn_level=1 and hdone=0: hcnt increments.
  - When hcnt == HOLD_CYCLES-1: hold_pulse[i] <= en, hdone <= 1, hcnt stops.
  - hold_pulse therefore fires exactly once per press, in the cycle after btn_level has been high for HOLD_CYCLES cycles. There is no auto-repeat.
  - A release before that point produces no hold_pulse.
- Encoder: combinational from the registered press_pulse, so it has the same timing.
  - press_idx is the lowest-index set bit (priority U>D>L>R>C).
  - press_multi = popcount(press_pulse) >= 2.
- en low: pulses that would have fired are dropped, not deferred. Raising en never generates a retroactive pulse.
- Reset mid-debounce or mid-hold: the counter is lost. A button still held after reset re-qualifies from zero and produces a fresh press_pulse.
- Independence: buttons are fully independent; simultaneous events on different bits are all reported.

Test Plan:
All scenarios use NUM_BTN=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.

1. Clean press: raise btn_raw[2] before edge E0 and hold -> btn_level[2]=1 and press_pulse[2]=1 at E5 only; press_valid=1, press_idx=2, press_multi=0 for that one cycle.
2. Bounce: on btn_raw[1], toggle 1/0 every 2 cycles for 20 cycles, then hold at 1 -> no press_pulse during the bounce; exactly one press_pulse[1], 5 edges after the final stable rise.
3. Hold: hold btn_raw[4] for 40 cycles after btn_level rises -> one hold_pulse[4], 20 cycles after the press_pulse, and no second pulse. On release -> release_pulse[4] 5 edges after btn_raw falls.
4. Simultaneous: raise btn_raw[1] and btn_raw[3] at the same edge -> press_pulse=5'b01010, press_idx=1, press_multi=1 in one cycle.
5. Enable gating: hold en=0 across a full press and release of btn_raw[0] -> btn_level[0] follows the button, all pulses stay 0. Set en=1 afterwards -> no late pulses.
6. Reset mid-hold: pulse rst_n low for 1 cycle while btn_raw[3] is held and btn_level[3]=1 -> outputs are 0 immediately (async). After release, a new press_pulse[3] appears 5 edges later and hold_pulse[3] 20 cycles after that.
